// File: rtl/speaker_i2s_tx_if.sv
// rtl/speaker_i2s_tx_if.sv - sample inputs and DAC pin bundle for speaker_i2s_tx
interface speaker_i2s_tx_if;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        sample_tick;
  logic [15:0] led_level;

  // Upstream side: supplies samples, observes the DAC pins and strobes
  modport master (
    output audio_left, audio_right,
    input  audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick, led_level
  );

  // Transmitter side
  modport slave (
    input  audio_left, audio_right,
    output audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick, led_level
  );
endinterface

// File: rtl/speaker_i2s_tx.sv
// rtl/speaker_i2s_tx.sv - Philips I2S transmitter for the Pmod I2S2 DAC; optional peak meter under SPK_PEAK_EN
module speaker_i2s_tx #(
  parameter int unsigned DECAY_FRAMES = 8192
) (
  input  logic           clk,
  input  logic           rst,
  speaker_i2s_tx_if.slave bus
);

  logic [8:0]  r_cnt;
  logic [31:0] r_frame;
  logic        r_sdin;
  logic        r_tick;
  logic        w_latch;
  logic [4:0]  w_slot;

  // cnt == 511 is the last clk of a frame: the only point where samples are taken
  assign w_latch = (r_cnt == 9'd511);
  assign w_slot  = r_cnt[8:4];

  // Free-running divider; every audio clock is a bit of this register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= r_cnt + 9'd1;
  end

  // Capture the stereo sample at frame end and flag it one clk later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_latch;
      if (w_latch) r_frame <= {bus.audio_left, bus.audio_right};
    end
  end

  // Load the next slot's bit on the sck falling edge (last clk of the current slot).
  // Slot k+1 carries S[31-k]; slot 0 carries the outgoing frame's R[0], read here
  // on the same edge that replaces the frame register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sdin <= 1'b0;
    end else if (r_cnt[3:0] == 4'hF) begin
      if (w_latch) r_sdin <= r_frame[0];
      else         r_sdin <= r_frame[~w_slot];
    end
  end

  assign bus.audio_mclk  = r_cnt[1];
  assign bus.audio_sck   = r_cnt[3];
  assign bus.audio_lrck  = r_cnt[8];
  assign bus.audio_sdin  = r_sdin;
  assign bus.sample_tick = r_tick;

`ifdef SPK_PEAK_EN
  localparam int unsigned DW = (DECAY_FRAMES > 2) ? $clog2(DECAY_FRAMES) : 1;
  // Counter value seen on the tick whose increment would reach DECAY_FRAMES-1
  localparam logic [DW-1:0] DECAY_LAST = (DECAY_FRAMES > 1) ? DW'(DECAY_FRAMES - 2) : '0;

  logic [14:0] r_peak;
  logic [DW-1:0] r_decay;
  logic [15:0] r_led;
  logic [14:0] w_mag_l;
  logic [14:0] w_mag_r;
  logic [14:0] w_mag;
  logic [4:0]  w_n;
  logic [15:0] w_therm;

  // |v| with -32768 clamped to 32767 so it fits 15 bits
  function automatic logic [14:0] mag15(input logic [15:0] v);
    logic [15:0] neg;
    neg = ~v + 16'd1;
    if (!v[15])  return v[14:0];
    if (neg[15]) return 15'h7FFF;
    return neg[14:0];
  endfunction

  // Larger channel magnitude of the latched sample
  always_comb begin
    w_mag_l = mag15(r_frame[31:16]);
    w_mag_r = mag15(r_frame[15:0]);
    w_mag   = (w_mag_l > w_mag_r) ? w_mag_l : w_mag_r;
  end

  // Peak hold with periodic halving once no louder sample has arrived
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak  <= '0;
      r_decay <= '0;
    end else if (r_tick) begin
      if (w_mag > r_peak) begin
        r_peak  <= w_mag;
        r_decay <= '0;
      end else if (r_decay >= DECAY_LAST) begin
        r_peak  <= r_peak >> 1;
        r_decay <= '0;
      end else begin
        r_decay <= r_decay + 1'b1;
      end
    end
  end

  // Thermometer code: top four magnitude bits plus one LED for any nonzero peak
  always_comb begin
    w_n = {1'b0, r_peak[14:11]} + {4'd0, |r_peak};
    w_therm = '0;
    for (int i = 0; i < 16; i++) w_therm[i] = (5'(i) < w_n);
  end

  // Meter register follows the peak one clk later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_led <= '0;
    else     r_led <= w_therm;
  end

  assign bus.led_level = r_led;
`else
  assign bus.led_level = 16'h0000;

  // DECAY_FRAMES only shapes the meter; keep it bound so both builds share one parameter list
  if (DECAY_FRAMES == 0) begin : g_decay_frames_zero
  end
`endif

endmodule
